hub75_scan_ctrl: RTL and testbench
==================================

// Module: hub75_scan_ctrl
// PURPOSE
//  Read-side controller for the HUB75 bit-plane frame memory; drives the LED panel chain.
//  - Scans rows 0..ROWS_HALF-1 and bit planes 7 down to 2 of each row.
//  - Issues rd_addr/rd_bit_plane to the memory and registers the returned r0..b1 bits.
//  - Shifts each plane's row data out on pnl_clk, latches it, then applies binary-coded
//    modulation: OE time doubles with each plane weight.
//  - Shifting of the next plane overlaps display of the current one.
// PARAMETERS
//  COLS       512  pixels per row across the chain (64 x 8 panels); power of 2
//  COL_W      9    log2(COLS)
//  ROWS_HALF  32   scanned rows (row n and n+32 driven together)
//  ROW_W      5    log2(ROWS_HALF)
//  BASE_ON    8    OE-active cycles for plane 2; plane p gets BASE_ON<<(p-2)
//  BLANK      2    OE-high cycles before and after each latch pulse
// PORTS
//  clk           in   1      system clock
//  reset         in   1      synchronous, active-high reset
//  enable        in   1      1 = run scan; 0 = stop at the next row boundary
//  rd_addr       out  14     memory read address = {row[ROW_W-1:0], col[COL_W-1:0]}
//  rd_bit_plane  out  3      plane select to memory, 3'd7..3'd2
//  r0,g0,b0      in   1      upper-half bits; valid 1 clk after rd_addr/rd_bit_plane
//  r1,g1,b1      in   1      lower-half bits; same timing
//  pnl_r0..pnl_b1 out 1 each registered colour data to panel
//  pnl_clk       out  1      panel shift clock
//  pnl_lat       out  1      panel latch, 1-cycle high pulse
//  pnl_oe_n      out  1      panel output enable, active low
//  pnl_row       out  ROW_W  panel row address A..E
//  frame_start   out  1      1-cycle pulse when row 0 / plane 7 shifting begins
// BEHAVIOUR
//  Reset: every output 0, except pnl_oe_n=1 and rd_bit_plane=7. FSM=IDLE; OE counter=0.
//  FSM states:
//   - IDLE: leave when enable=1. Go to SHIFT with row=0, plane=7; pulse frame_start.
//   - SHIFT: 2*COLS+1 cycles.
//     - Cycle 0 prefetches col 0.
//     - Pixel c then takes 2 cycles:
//       - phase A: pnl_clk=0, pnl_rgb <= memory bits for col c, rd_addr advances to c+1.
//       - phase B: pnl_clk=1.
//     - rd_bit_plane is held constant for the whole SHIFT.
//     - pnl_clk returns to 0 on exit. rd_addr wraps col to 0 after COLS-1 (no carry into row).
//   - WAIT_OE: hold until OE counter = 0 (previous plane's display finished).
//   - BLANK_PRE: BLANK cycles, pnl_oe_n=1.
//   - LATCH: 1 cycle.
//     - pnl_lat=1; pnl_row <= row of shifted data.
//     - Load OE counter with BASE_ON<<(plane-2).
//   - BLANK_POST: BLANK cycles, pnl_oe_n=1. Then OE counter decrements each cycle,
//     with pnl_oe_n=0 while counter != 0.
//   - Next plane: go to SHIFT with plane-1.
//     - After plane 2: plane=7 and row+1.
//     - Row ROWS_HALF-1 wraps to 0; frame_start pulses on the SHIFT entry for row 0.
//  - Plane 2 carries green only; memory returns 0 for R/B and the bits are shifted as-is.
//  - enable=0 is sampled at the end of plane 2's BLANK_POST. That plane's display
//    completes, then the FSM returns to IDLE with pnl_oe_n=1. Mid-row deassert has no effect.
//  - OE counter and SHIFT run concurrently. When display time < shift time, WAIT_OE is
//    0 cycles (zero-length state permitted).
//  - pnl_oe_n is forced 1 in IDLE, WAIT_OE-to-BLANK transitions, BLANK_PRE, LATCH and BLANK_POST.
//  - reset mid-operation: next cycle equals reset state. pnl_oe_n=1, no stray pnl_lat or pnl_clk edge.
// TESTING
//  1. COLS=4, BASE_ON=8, model memory returns col-indexed pattern; enable=1 ->
//     frame_start at cycle 1; 4 pnl_clk rises per plane; pnl_rgb equals memory at rd_addr of prior cycle.
//  2. Same setup, measure OE low per plane -> 256,128,64,32,16,8 cycles for planes 7..2;
//     never low while pnl_lat=1 or within BLANK cycles of it.
//  3. Run full frame, ROWS_HALF=32 -> pnl_row steps 0..31 at latches; after row 31 plane 2,
//     row wraps to 0, frame_start re-pulses; rd_addr row field matches.
//  4. COLS=512, BASE_ON=1 (shift-bound) -> WAIT_OE zero length; OE low exactly BASE_ON<<(p-2)
//     cycles; latch period = 2*512+1+2*BLANK+1 cycles.
//  5. Deassert enable during row 3 plane 5 -> row 3 completes through plane 2 display,
//     IDLE, pnl_oe_n=1, rd_addr/pnl_clk static; re-enable -> restarts at row 0 plane 7.
//  6. Assert reset during SHIFT and during OE-active -> next cycle pnl_oe_n=1, pnl_clk=0,
//     pnl_lat=0, pnl_row=0, rd_bit_plane=7.

Source files
------------

// File: rtl/hub75_scan_ctrl.sv
// Purpose : read-side scan controller for a HUB75 bit-plane frame memory driving an LED panel chain.
// Latency : memory bits registered 1 clk after rd_addr; each plane is shifted while the previous plane is displayed.
// Backpressure: none; enable=0 is honoured only at a row boundary (after plane 2 of the current row has been displayed).
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   enable               1 = keep scanning, 0 = stop after the current row
//   rd_addr              {row, col} read address to the frame memory
//   rd_bit_plane         bit plane being read (7 down to 2)
//   r0,g0,b0,r1,g1,b1    memory read data, upper / lower half of the panel
//   pnl_r0..pnl_b1       registered colour bits to the panel
//   pnl_clk, pnl_lat     panel shift clock and 1-cycle latch pulse
//   pnl_oe_n             panel output enable, active low
//   pnl_row              panel row address (A..E)
//   frame_start          1-cycle pulse when row 0 / plane 7 shifting begins
module hub75_scan_ctrl #(
    parameter int COLS      = 512,
    parameter int COL_W     = 9,
    parameter int ROWS_HALF = 32,
    parameter int ROW_W     = 5,
    parameter int BASE_ON   = 8,
    parameter int BLANK     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    output logic [ROW_W+COL_W-1:0] rd_addr,
    output logic [2:0]             rd_bit_plane,
    input  logic                   r0,
    input  logic                   g0,
    input  logic                   b0,
    input  logic                   r1,
    input  logic                   g1,
    input  logic                   b1,
    output logic                   pnl_r0,
    output logic                   pnl_g0,
    output logic                   pnl_b0,
    output logic                   pnl_r1,
    output logic                   pnl_g1,
    output logic                   pnl_b1,
    output logic                   pnl_clk,
    output logic                   pnl_lat,
    output logic                   pnl_oe_n,
    output logic [ROW_W-1:0]       pnl_row,
    output logic                   frame_start
);

    // Phase counter must reach 2*COLS (the last SHIFT cycle), which needs COL_W+2 bits.
    localparam int CYC_W = COL_W + 2;
    // Largest display time is plane 7: BASE_ON << 5.
    localparam int OE_W  = $clog2((BASE_ON << 5) + 1);

    localparam logic [CYC_W-1:0] SHIFT_LAST = CYC_W'(2 * COLS);
    localparam logic [CYC_W-1:0] BLANK_LAST = CYC_W'(BLANK - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS_HALF - 1);
    localparam logic [2:0]       PLANE_HI   = 3'd7;
    localparam logic [2:0]       PLANE_LO   = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT_OE,
        S_BLANK_PRE,
        S_LATCH,
        S_BLANK_POST,
        S_DRAIN
    } state_t;

    state_t            state;
    state_t            state_d;

    logic [CYC_W-1:0]  cyc;       // cycles spent in the current state
    logic [ROW_W-1:0]  row;       // row currently being shifted
    logic [COL_W-1:0]  col;       // column currently addressed
    logic [2:0]        plane;     // plane currently being shifted
    logic [OE_W-1:0]   oe_cnt;    // remaining display cycles of the latched plane

    // Control strobes from the output decoder
    logic              phase_a;
    logic              phase_b;
    logic              lat_d;
    logic              oe_load;
    logic              oe_run;
    logic              plane_start;
    logic              frame_start_d;
    logic [ROW_W-1:0]  row_d;
    logic [2:0]        plane_d;

    // rd_addr and rd_bit_plane come straight from registers.
    assign rd_addr      = {row, col};
    assign rd_bit_plane = plane;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Skip WAIT_OE entirely when the previous plane already finished.
                if (cyc == SHIFT_LAST) begin
                    state_d = (oe_cnt == '0) ? S_BLANK_PRE : S_WAIT_OE;
                end
            end
            S_WAIT_OE: begin
                if (oe_cnt == '0) begin
                    state_d = S_BLANK_PRE;
                end
            end
            S_BLANK_PRE: begin
                if (cyc == BLANK_LAST) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                state_d = S_BLANK_POST;
            end
            S_BLANK_POST: begin
                // enable only matters at the row boundary: after plane 2 is latched.
                if (cyc == BLANK_LAST) begin
                    state_d = ((plane == PLANE_LO) && !enable) ? S_DRAIN : S_SHIFT;
                end
            end
            S_DRAIN: begin
                // Let the last plane's display run out before going idle.
                if (oe_cnt == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        phase_a     = 1'b0;
        phase_b     = 1'b0;
        lat_d       = 1'b0;
        oe_load     = 1'b0;
        oe_run      = 1'b0;
        plane_start = 1'b0;
        row_d       = row;
        plane_d     = plane;

        case (state)
            S_SHIFT: begin
                // Cycle 0 is the column-0 prefetch; odd cycles are phase A, even
                // non-zero cycles are phase B of the same pixel.
                phase_a = cyc[0];
                phase_b = !cyc[0] && (cyc != '0);
                oe_run  = (oe_cnt != '0);
            end
            S_WAIT_OE, S_DRAIN: begin
                oe_run = (oe_cnt != '0);
            end
            S_LATCH: begin
                lat_d   = 1'b1;
                oe_load = 1'b1;
            end
            default: begin
            end
        endcase

        // Row / plane advance on every entry into SHIFT.
        if ((state != S_SHIFT) && (state_d == S_SHIFT)) begin
            plane_start = 1'b1;
            if (state == S_IDLE) begin
                row_d   = '0;
                plane_d = PLANE_HI;
            end else if (plane == PLANE_LO) begin
                plane_d = PLANE_HI;
                row_d   = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
                plane_d = plane - 3'd1;
            end
        end

        frame_start_d = plane_start && (row_d == '0) && (plane_d == PLANE_HI);
    end

    // ------------------------------------------------------------------
    // Datapath and registered panel outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc         <= '0;
            row         <= '0;
            col         <= '0;
            plane       <= PLANE_HI;
            oe_cnt      <= '0;
            pnl_r0      <= 1'b0;
            pnl_g0      <= 1'b0;
            pnl_b0      <= 1'b0;
            pnl_r1      <= 1'b0;
            pnl_g1      <= 1'b0;
            pnl_b1      <= 1'b0;
            pnl_clk     <= 1'b0;
            pnl_lat     <= 1'b0;
            pnl_oe_n    <= 1'b1;
            pnl_row     <= '0;
            frame_start <= 1'b0;
        end else begin
            cyc   <= (state_d != state) ? '0 : cyc + CYC_W'(1);
            row   <= row_d;
            plane <= plane_d;

            // Column wraps naturally after COLS-1, leaving col=0 ready for the
            // next plane's prefetch without touching the row field.
            if (phase_a) begin
                col <= col + COL_W'(1);
            end

            if (oe_load) begin
                oe_cnt <= OE_W'(BASE_ON) << (plane - PLANE_LO);
            end else if (oe_run) begin
                oe_cnt <= oe_cnt - OE_W'(1);
            end

            // Registered one cycle behind oe_run so pnl_oe_n is glitch-free; the
            // low window keeps the exact length of the counter load.
            pnl_oe_n <= !oe_run;

            // Data is loaded in phase A so it is stable a full cycle before the
            // panel clock rises in phase B.
            pnl_clk <= phase_b;
            if (phase_a) begin
                {pnl_r0, pnl_g0, pnl_b0, pnl_r1, pnl_g1, pnl_b1} <= {r0, g0, b0, r1, g1, b1};
            end

            pnl_lat <= lat_d;
            if (lat_d) begin
                pnl_row <= row;
            end

            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
module tb_hub75_scan_ctrl;

    localparam int COLS      = 4;
    localparam int COL_W     = 2;
    localparam int ROWS_HALF = 4;
    localparam int ROW_W     = 2;
    localparam int BASE_ON   = 8;
    localparam int BLANK     = 2;
    localparam int AW        = ROW_W + COL_W;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [AW-1:0] rd_addr;
    logic [2:0]    rd_bit_plane;
    logic          r0, g0, b0, r1, g1, b1;
    logic          pnl_r0, pnl_g0, pnl_b0, pnl_r1, pnl_g1, pnl_b1;
    logic          pnl_clk, pnl_lat, pnl_oe_n;
    logic [ROW_W-1:0] pnl_row;
    logic          frame_start;

    hub75_scan_ctrl #(
        .COLS(COLS), .COL_W(COL_W), .ROWS_HALF(ROWS_HALF),
        .ROW_W(ROW_W), .BASE_ON(BASE_ON), .BLANK(BLANK)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .rd_addr(rd_addr), .rd_bit_plane(rd_bit_plane),
        .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
        .pnl_r0(pnl_r0), .pnl_g0(pnl_g0), .pnl_b0(pnl_b0),
        .pnl_r1(pnl_r1), .pnl_g1(pnl_g1), .pnl_b1(pnl_b1),
        .pnl_clk(pnl_clk), .pnl_lat(pnl_lat), .pnl_oe_n(pnl_oe_n),
        .pnl_row(pnl_row), .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame memory content: column-indexed pattern; plane 2 holds green only.
    function automatic logic [5:0] mem_f(input logic [ROW_W-1:0] row,
                                         input logic [COL_W-1:0] col,
                                         input logic [2:0] plane);
        logic [5:0] v;
        v = 6'((int'(col) * 11 + int'(row) * 5 + int'(plane) * 3 + 7) % 64);
        if (plane == 3'd2) v = v & 6'b010010;
        return v;
    endfunction

    // Memory model with one clock of read latency.
    always @(posedge clk)
        {r0, g0, b0, r1, g1, b1} <= mem_f(rd_addr[AW-1:COL_W], rd_addr[COL_W-1:0], rd_bit_plane);

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [2:0]       plane;
        logic [5:0]       dat;
    } pix_t;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [2:0]       plane;
    } lat_t;

    pix_t pix_q[$];
    lat_t lat_q[$];

    int checks = 0;
    int errors = 0;

    // Monitor state
    bit mon_en = 1'b0;
    logic prev_clk = 1'b0;
    logic prev_oe_n = 1'b1;
    int cyc_no = 0;
    int since_lat = 1000;
    int since_oe_low = 1000;
    int oe_run = 0;
    int cur_on = 0;
    int exp_period = 0;
    int last_lat = 0;
    bit have_lat = 1'b0;
    int lat_cnt = 0;
    int fs_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected traffic for one row: 6 planes, each COLS pixels then a latch.
    task automatic push_row(input int r);
        pix_t p;
        lat_t l;
        for (int pl = 7; pl >= 2; pl--) begin
            for (int c = 0; c < COLS; c++) begin
                p.row   = ROW_W'(r);
                p.plane = 3'(pl);
                p.dat   = mem_f(ROW_W'(r), COL_W'(c), 3'(pl));
                pix_q.push_back(p);
            end
            l.row   = ROW_W'(r);
            l.plane = 3'(pl);
            lat_q.push_back(l);
        end
    endtask

    task automatic mon_cycle();
        pix_t p;
        lat_t l;
        int on_n;
        if (pnl_lat) since_lat = 0;
        else if (since_lat < 1000) since_lat++;

        if (pnl_clk && !prev_clk) begin
            check("pix_avail", 32'(pix_q.size() != 0), 1);
            if (pix_q.size() != 0) begin
                p = pix_q.pop_front();
                check("pix_dat", {pnl_r0, pnl_g0, pnl_b0, pnl_r1, pnl_g1, pnl_b1}, p.dat);
                check("pix_plane", rd_bit_plane, p.plane);
                check("pix_addr_row", rd_addr[AW-1:COL_W], p.row);
            end
        end

        if (pnl_lat) begin
            check("lat_avail", 32'(lat_q.size() != 0), 1);
            if (lat_q.size() != 0) begin
                l = lat_q.pop_front();
                check("lat_row", pnl_row, l.row);
                check("lat_oe_n", pnl_oe_n, 1);
                check("lat_pre_blank", 32'(since_oe_low >= BLANK), 1);
                if (have_lat) check("lat_period", cyc_no - last_lat, exp_period);
                have_lat = 1'b1;
                last_lat = cyc_no;
                on_n = BASE_ON << (int'(l.plane) - 2);
                cur_on = on_n;
                exp_period = ((on_n > 2 * COLS) ? on_n : 2 * COLS) + 2 * BLANK + 2;
                lat_cnt++;
            end
        end

        if (!pnl_oe_n) begin
            if (prev_oe_n) check("oe_post_blank", 32'(since_lat > BLANK), 1);
            oe_run++;
        end else if (!prev_oe_n) begin
            check("oe_width", oe_run, cur_on);
            oe_run = 0;
        end

        if (frame_start) begin
            fs_cnt++;
            check("fs_plane", rd_bit_plane, 7);
            check("fs_addr_row", rd_addr[AW-1:COL_W], 0);
        end

        if (!pnl_oe_n) since_oe_low = 0;
        else if (since_oe_low < 1000) since_oe_low++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc_no++;
            if (mon_en) mon_cycle();
            prev_clk  = pnl_clk;
            prev_oe_n = pnl_oe_n;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_oe_n"}, pnl_oe_n, 1);
        check({tag, "_pnl_clk"}, pnl_clk, 0);
        check({tag, "_pnl_lat"}, pnl_lat, 0);
        check({tag, "_pnl_row"}, pnl_row, 0);
        check({tag, "_plane"}, rd_bit_plane, 7);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_frame_start"}, frame_start, 0);
        check({tag, "_rgb"}, {pnl_r0, pnl_g0, pnl_b0, pnl_r1, pnl_g1, pnl_b1}, 0);
    endtask

    initial begin
        logic [AW-1:0] addr_hold;
        int budget;

        reset  = 1'b1;
        enable = 1'b0;
        step(3);
        check_reset_state("rst");
        reset = 1'b0;
        step(3);
        check("idle_oe_n", pnl_oe_n, 1);
        check("idle_no_fs", frame_start, 0);

        // Two frames expected; enable drops during row 3 plane 5 of the second.
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < ROWS_HALF; r++) push_row(r);

        mon_en = 1'b1;
        enable = 1'b1;
        step(1);
        check("fs_cycle1", frame_start, 1);
        step(1);
        check("fs_one_cycle", frame_start, 0);

        budget = 8000;
        while (lat_cnt < 44 && budget > 0) begin step(1); budget--; end
        check("reach_row3_plane6", lat_cnt, 44);
        check("frame_wrapped", fs_cnt, 2);

        step(4);
        enable = 1'b0;
        budget = 1000;
        while (lat_cnt < 48 && budget > 0) begin step(1); budget--; end
        check("row3_completes", lat_cnt, 48);

        step(40);
        check("stop_oe_n", pnl_oe_n, 1);
        check("stop_pix_drained", pix_q.size(), 0);
        check("stop_lat_drained", lat_q.size(), 0);
        addr_hold = rd_addr;
        step(30);
        check("stop_addr_static", rd_addr, addr_hold);
        check("stop_pnl_clk", pnl_clk, 0);
        check("stop_no_latch", lat_cnt, 48);
        check("stop_no_fs", fs_cnt, 2);
        check("stop_oe_n_held", pnl_oe_n, 1);

        // Restart, then reset during SHIFT and during display.
        mon_en = 1'b0;
        enable = 1'b1;
        step(1);
        check("restart_fs", frame_start, 1);
        check("restart_addr", rd_addr, 0);
        check("restart_plane", rd_bit_plane, 7);
        step(6);
        reset = 1'b1;
        step(1);
        check_reset_state("rst_shift");
        reset = 1'b0;

        budget = 500;
        while (pnl_oe_n && budget > 0) begin step(1); budget--; end
        check("oe_active_reached", pnl_oe_n, 0);
        reset = 1'b1;
        step(1);
        check_reset_state("rst_oe");
        enable = 1'b0;
        step(2);
        reset = 1'b0;
        step(3);
        check("post_reset_idle_oe_n", pnl_oe_n, 1);
        check("post_reset_idle_lat", pnl_lat, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
